// File: rtl/scan_frame_loader_pkg.sv
// ---------------------------------------------------------------------------
// scan_pkg : shared definitions for the scan frame loader.
//   - state_t            : FSM encoding (IDLE=0, SHIFT=1, SETUP=2, PULSE=3)
//   - DEFAULT_WIDTH      : default number of control bits per frame
//   - DEFAULT_LOAD_CYCLES: default LOAD high time in SCAN_CLK cycles
//   - frame_len()        : serial frame length for a given data width
// Optional build macro: PARITY_CHECK_EN (adds one odd-parity bit per frame).
// ---------------------------------------------------------------------------
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SETUP = 2'd2,
        PULSE = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH       = 5;
    localparam int DEFAULT_LOAD_CYCLES = 2;

`ifdef PARITY_CHECK_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Number of serial bits in one well-formed frame.
    function automatic int frame_len(input int width);
        return width + PARITY_BITS;
    endfunction

endpackage

// File: rtl/scan_frame_loader_if.sv
// ---------------------------------------------------------------------------
// scan_frame_loader_if : serial-in / parallel-out bus of the scan loader.
//   master : drives SCAN_EN, SCAN_IN, ERR_CLR; observes the loader outputs
//   slave  : the loader itself (PAR_OUT, LOAD, BUSY, SCAN_OUT, error flags)
// PAR_OUT is [0:WIDTH-1]; index 0 holds the first bit of the frame.
// ---------------------------------------------------------------------------
interface scan_frame_loader_if #(
    parameter int WIDTH = scan_pkg::DEFAULT_WIDTH
);
    logic               SCAN_EN;
    logic               SCAN_IN;
    logic               ERR_CLR;
    logic [0:WIDTH-1]   PAR_OUT;
    logic               LOAD;
    logic               BUSY;
    logic               SCAN_OUT;
    logic               FRAME_ERR;
    logic               PARITY_ERR;

    modport master (
        output SCAN_EN, SCAN_IN, ERR_CLR,
        input  PAR_OUT, LOAD, BUSY, SCAN_OUT, FRAME_ERR, PARITY_ERR
    );

    modport slave (
        input  SCAN_EN, SCAN_IN, ERR_CLR,
        output PAR_OUT, LOAD, BUSY, SCAN_OUT, FRAME_ERR, PARITY_ERR
    );
endinterface

// File: rtl/scan_frame_loader_shift_reg.sv
// ---------------------------------------------------------------------------
// scan_shift_reg : serial shift register plus saturating bit counter.
//   clk, srst   : clock, synchronous active-high reset
//   shift_en_i  : shift SCAN_IN into the top stage, move others toward 0
//   clr_i       : clear the bit counter (shift register contents kept)
//   scan_in_i   : serial data
//   frame_o     : [0:FLEN-1] register contents, index 0 = oldest bit
//   count_o     : bits shifted since last clear, saturates at FLEN+1
// ---------------------------------------------------------------------------
module scan_shift_reg #(
    parameter int FLEN = 5
) (
    input  logic                        clk,
    input  logic                        srst,
    input  logic                        shift_en_i,
    input  logic                        clr_i,
    input  logic                        scan_in_i,
    output logic [0:FLEN-1]             frame_o,
    output logic [$clog2(FLEN+2)-1:0]   count_o
);
    localparam int CW = $clog2(FLEN + 2);

    logic [0:FLEN-1] sr_q;
    logic [CW-1:0]   cnt_q;

    genvar gi;
    generate
        for (gi = 0; gi < FLEN; gi++) begin : g_stage
            if (gi == FLEN - 1) begin : g_top
                always_ff @(posedge clk) begin
                    if (srst)            sr_q[gi] <= 1'b0;
                    else if (shift_en_i) sr_q[gi] <= scan_in_i;
                end
            end else begin : g_mid
                always_ff @(posedge clk) begin
                    if (srst)            sr_q[gi] <= 1'b0;
                    else if (shift_en_i) sr_q[gi] <= sr_q[gi+1];
                end
            end
        end
    endgenerate

    // Saturating at FLEN+1 is enough to tell "too long" from "exact".
    always_ff @(posedge clk) begin
        if (srst || clr_i) begin
            cnt_q <= '0;
        end else if (shift_en_i && (cnt_q != CW'(FLEN + 1))) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign frame_o = sr_q;
    assign count_o = cnt_q;

endmodule

// File: rtl/scan_frame_loader.sv
// ---------------------------------------------------------------------------
// scan_frame_loader : serial scan-in front end for a control-signal latch.
//   SCAN_CLK : single clock, rising edge
//   RESET    : synchronous active-high reset
//   bus      : scan_frame_loader_if.slave
//              SCAN_EN/SCAN_IN/ERR_CLR in; PAR_OUT, LOAD, BUSY, SCAN_OUT,
//              FRAME_ERR, PARITY_ERR out
// A frame is shifted while SCAN_EN=1; the edge that sees SCAN_EN=0 ends it.
// A good frame updates PAR_OUT on that edge, LOAD rises one edge later and
// stays high LOAD_CYCLES cycles. Scan input is ignored while BUSY.
// Optional build macro: PARITY_CHECK_EN (odd parity bit after the data).
// ---------------------------------------------------------------------------
module scan_frame_loader
    import scan_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int LOAD_CYCLES = DEFAULT_LOAD_CYCLES
) (
    input  logic                 SCAN_CLK,
    input  logic                 RESET,
    scan_frame_loader_if.slave   bus
);
    localparam int FLEN = frame_len(WIDTH);
    localparam int CW   = $clog2(FLEN + 2);
    localparam int PCW  = $clog2(LOAD_CYCLES + 1);

    state_t           state_q;
    logic [PCW-1:0]   pcnt_q;
    logic [0:WIDTH-1] par_out_q;
    logic             load_q;
    logic             busy_q;
    logic             frame_err_q;

    logic [0:FLEN-1]  frame;
    logic [CW-1:0]    count;
    logic             shift_en;
    logic             frame_end;
    logic             len_ok;
    logic             parity_ok;
    logic             set_frame_err;

    assign shift_en  = bus.SCAN_EN && ((state_q == IDLE) || (state_q == SHIFT));
    assign frame_end = (state_q == SHIFT) && !bus.SCAN_EN;
    assign len_ok    = (count == CW'(FLEN));

`ifdef PARITY_CHECK_EN
    // Odd parity over data + parity bit.
    assign parity_ok = ^frame;
`else
    assign parity_ok = 1'b1;
`endif

    assign set_frame_err = frame_end && !len_ok;

    scan_shift_reg #(
        .FLEN (FLEN)
    ) u_shift (
        .clk        (SCAN_CLK),
        .srst       (RESET),
        .shift_en_i (shift_en),
        .clr_i      (frame_end),
        .scan_in_i  (bus.SCAN_IN),
        .frame_o    (frame),
        .count_o    (count)
    );

    always_ff @(posedge SCAN_CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            pcnt_q      <= '0;
            par_out_q   <= '0;
            load_q      <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            // A new error on the same edge as ERR_CLR wins.
            frame_err_q <= set_frame_err | (frame_err_q & ~bus.ERR_CLR);
            case (state_q)
                IDLE: begin
                    if (bus.SCAN_EN) state_q <= SHIFT;
                end
                SHIFT: begin
                    if (!bus.SCAN_EN) begin
                        if (len_ok && parity_ok) begin
                            par_out_q <= frame[0:WIDTH-1];
                            busy_q    <= 1'b1;
                            state_q   <= SETUP;
                        end else begin
                            state_q   <= IDLE;
                        end
                    end
                end
                SETUP: begin
                    load_q  <= 1'b1;
                    pcnt_q  <= '0;
                    state_q <= PULSE;
                end
                PULSE: begin
                    if (pcnt_q == PCW'(LOAD_CYCLES - 1)) begin
                        load_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        pcnt_q  <= pcnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef PARITY_CHECK_EN
    logic parity_err_q;
    always_ff @(posedge SCAN_CLK) begin
        if (RESET) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= (frame_end && len_ok && !parity_ok)
                          | (parity_err_q & ~bus.ERR_CLR);
        end
    end
    assign bus.PARITY_ERR = parity_err_q;
`else
    assign bus.PARITY_ERR = 1'b0;
`endif

    assign bus.PAR_OUT   = par_out_q;
    assign bus.LOAD      = load_q;
    assign bus.BUSY      = busy_q;
    assign bus.SCAN_OUT  = frame[0];
    assign bus.FRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_scan_frame_loader.sv
// ---------------------------------------------------------------------------
// tb_scan_frame_loader : directed self-checking bench for scan_frame_loader.
// A frame-level model (bit queue + commit timer) is checked every cycle;
// directed steps also pin literal expectations.
// Optional build macro: PARITY_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_scan_frame_loader;
    localparam int WIDTH = 5;
    localparam int LC    = 2;
`ifdef PARITY_CHECK_EN
    localparam int FLEN  = WIDTH + 1;
    localparam bit PAR   = 1'b1;
`else
    localparam int FLEN  = WIDTH;
    localparam bit PAR   = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    scan_frame_loader_if #(.WIDTH(WIDTH)) bus ();

    scan_frame_loader #(
        .WIDTH       (WIDTH),
        .LOAD_CYCLES (LC)
    ) dut (
        .SCAN_CLK (clk),
        .RESET    (rst),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    logic             m_hist[$];     // last FLEN bits shifted, oldest first
    int               m_n;           // bits in the frame being received
    int               m_sc;          // edges since commit, -1 when not busy
    logic [0:WIDTH-1] m_par;
    logic             m_ferr, m_perr;
    bit               m_busy_b, m_set_f, m_set_p, m_x;

    always @(posedge clk) begin
        if (rst) begin
            m_hist.delete();
            for (int i = 0; i < FLEN; i++) m_hist.push_back(1'b0);
            m_n = 0; m_sc = -1; m_par = '0; m_ferr = 0; m_perr = 0;
        end else begin
            m_busy_b = (m_sc >= 0);
            m_set_f  = 0;
            m_set_p  = 0;
            if (m_sc >= 0) begin
                m_sc++;
                if (m_sc > LC) m_sc = -1;
            end
            if (!m_busy_b && bus.SCAN_EN) begin
                m_hist.push_back(bus.SCAN_IN);
                if (m_hist.size() > FLEN) void'(m_hist.pop_front());
                m_n++;
            end else if (!m_busy_b && m_n > 0) begin
                m_x = 0;
                for (int i = 0; i < FLEN; i++) m_x ^= m_hist[i];
                if (m_n != FLEN)     m_set_f = 1;
                else if (PAR && !m_x) m_set_p = 1;
                else begin
                    for (int i = 0; i < WIDTH; i++) m_par[i] = m_hist[i];
                    m_sc = 0;
                end
                m_n = 0;
            end
            m_ferr = m_set_f | (m_ferr & !bus.ERR_CLR);
            m_perr = m_set_p | (m_perr & !bus.ERR_CLR);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_PAR_OUT",    32'(bus.PAR_OUT),    32'(m_par));
            chk("model_LOAD",       32'(bus.LOAD),       32'(m_sc >= 1));
            chk("model_BUSY",       32'(bus.BUSY),       32'(m_sc >= 0));
            chk("model_SCAN_OUT",   32'(bus.SCAN_OUT),   32'(m_hist[0]));
            chk("model_FRAME_ERR",  32'(bus.FRAME_ERR),  32'(m_ferr));
            chk("model_PARITY_ERR", 32'(bus.PARITY_ERR), 32'(m_perr));
        end
    end

    // ---------------- stimulus helpers ----------------
    // bits[i] is the i-th bit sent.
    task automatic send(input logic [15:0] bits, input int n, input logic clr_end);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.SCAN_EN = 1'b1;
            bus.SCAN_IN = bits[i];
        end
        @(negedge clk);
        bus.SCAN_EN = 1'b0;
        bus.SCAN_IN = 1'b0;
        bus.ERR_CLR = clr_end;
        @(negedge clk);
        bus.ERR_CLR = 1'b0;
        $display("frame: %0d bits 0x%0h clr=%0b -> PAR_OUT=%b LOAD=%b FERR=%b PERR=%b",
                 n, bits, clr_end, bus.PAR_OUT, bus.LOAD, bus.FRAME_ERR, bus.PARITY_ERR);
    endtask

    // Data word plus a correct odd-parity bit when parity is compiled in.
    function automatic logic [15:0] good_word(input logic [4:0] d);
        logic [15:0] w;
        w = 16'(d);
        if (PAR) w[WIDTH] = ~^d;
        return w;
    endfunction

    task automatic count_pulses(output int load_c, output int busy_c, input int cyc);
        load_c = 0; busy_c = 0;
        for (int k = 0; k < cyc; k++) begin
            if (bus.LOAD) load_c++;
            if (bus.BUSY) busy_c++;
            @(negedge clk);
        end
    endtask

    int lc_n, bc_n;

    initial begin
        rst = 1'b1;
        bus.SCAN_EN = 1'b0; bus.SCAN_IN = 1'b0; bus.ERR_CLR = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_on = 1'b1;
        repeat (10) @(negedge clk);
        $display("reset + 10 idle cycles");
        chk("reset_PAR_OUT",  32'(bus.PAR_OUT), 32'h0);
        chk("reset_LOAD",     32'(bus.LOAD), 32'h0);
        chk("reset_BUSY",     32'(bus.BUSY), 32'h0);
        chk("reset_SCAN_OUT", 32'(bus.SCAN_OUT), 32'h0);
        chk("reset_FERR",     32'(bus.FRAME_ERR), 32'h0);
        chk("reset_PERR",     32'(bus.PARITY_ERR), 32'h0);

        // Good frame 1,0,1,1,0
        send(good_word(5'b01101), FLEN, 1'b0);
        chk("good_PAR_OUT", 32'(bus.PAR_OUT), 32'h16);
        chk("good_LOAD_at_commit", 32'(bus.LOAD), 32'h0);
        count_pulses(lc_n, bc_n, 6);
        chk("good_LOAD_cycles", 32'(lc_n), 32'd2);
        chk("good_BUSY_cycles", 32'(bc_n), 32'd3);

        // 4-bit frame
        send(16'h000F, 4, 1'b0);
        chk("short_FERR",    32'(bus.FRAME_ERR), 32'h1);
        chk("short_PAR_OUT", 32'(bus.PAR_OUT), 32'h16);
        count_pulses(lc_n, bc_n, 4);
        chk("short_no_LOAD", 32'(lc_n), 32'd0);

        // Clear, then 7-bit frame
        @(negedge clk); bus.ERR_CLR = 1'b1;
        @(negedge clk); bus.ERR_CLR = 1'b0;
        chk("clr_FERR", 32'(bus.FRAME_ERR), 32'h0);
        send(16'h0055, 7, 1'b0);
        chk("long_FERR",    32'(bus.FRAME_ERR), 32'h1);
        chk("long_PAR_OUT", 32'(bus.PAR_OUT), 32'h16);
        count_pulses(lc_n, bc_n, 4);
        chk("long_no_LOAD", 32'(lc_n), 32'd0);

        // Clear, then new error on the same edge as ERR_CLR
        @(negedge clk); bus.ERR_CLR = 1'b1;
        @(negedge clk); bus.ERR_CLR = 1'b0;
        send(16'h0003, 4, 1'b1);
        chk("setwins_FERR", 32'(bus.FRAME_ERR), 32'h1);

        // Reset in the 3rd shift cycle
        @(negedge clk); bus.SCAN_EN = 1'b1; bus.SCAN_IN = 1'b1;
        @(negedge clk); bus.SCAN_IN = 1'b0;
        @(negedge clk); bus.SCAN_IN = 1'b1; rst = 1'b1;
        @(negedge clk); rst = 1'b0; bus.SCAN_EN = 1'b0; bus.SCAN_IN = 1'b0;
        $display("reset mid-frame");
        chk("rstshift_PAR_OUT", 32'(bus.PAR_OUT), 32'h0);
        chk("rstshift_FERR",    32'(bus.FRAME_ERR), 32'h0);
        chk("rstshift_SCAN_OUT",32'(bus.SCAN_OUT), 32'h0);

        // Good frame 0,1,1,0,1
        send(good_word(5'b10110), FLEN, 1'b0);
        chk("good2_PAR_OUT", 32'(bus.PAR_OUT), 32'h0D);
        @(negedge clk);
        chk("good2_LOAD_rise", 32'(bus.LOAD), 32'h1);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        $display("reset during PULSE");
        chk("rstpulse_LOAD",    32'(bus.LOAD), 32'h0);
        chk("rstpulse_BUSY",    32'(bus.BUSY), 32'h0);
        chk("rstpulse_PAR_OUT", 32'(bus.PAR_OUT), 32'h0);

        // Good frame 1,1,0,0,1 then SCAN_EN held through SETUP/PULSE
        for (int i = 0; i < FLEN; i++) begin
            @(negedge clk);
            bus.SCAN_EN = 1'b1;
            bus.SCAN_IN = good_word(5'b10011) >> i;
        end
        @(negedge clk); bus.SCAN_EN = 1'b0; bus.SCAN_IN = 1'b0;
        @(negedge clk); bus.SCAN_EN = 1'b1; bus.SCAN_IN = 1'b1;
        chk("held_PAR_OUT", 32'(bus.PAR_OUT), 32'h19);
        repeat (5) @(negedge clk);
        bus.SCAN_EN = 1'b0; bus.SCAN_IN = 1'b0;
        @(negedge clk);
        $display("SCAN_EN held through commit -> FERR=%b", bus.FRAME_ERR);
        chk("held_FERR",     32'(bus.FRAME_ERR), 32'h1);
        chk("held_PAR_kept", 32'(bus.PAR_OUT), 32'h19);
        @(negedge clk); bus.ERR_CLR = 1'b1;
        @(negedge clk); bus.ERR_CLR = 1'b0;

`ifdef PARITY_CHECK_EN
        // 1,0,1,1,0 + parity 0 -> commit
        send(16'h000D, 6, 1'b0);
        chk("par_ok_PAR_OUT", 32'(bus.PAR_OUT), 32'h16);
        chk("par_ok_PERR",    32'(bus.PARITY_ERR), 32'h0);
        count_pulses(lc_n, bc_n, 5);
        chk("par_ok_LOAD", 32'(lc_n), 32'd2);
        // 0,0,1,1,1 + parity 1 -> parity error, no commit
        send(16'h003C, 6, 1'b0);
        chk("par_bad_PERR",    32'(bus.PARITY_ERR), 32'h1);
        chk("par_bad_PAR_OUT", 32'(bus.PAR_OUT), 32'h16);
        count_pulses(lc_n, bc_n, 4);
        chk("par_bad_no_LOAD", 32'(lc_n), 32'd0);
`endif

        repeat (3) @(negedge clk);
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_frame_loader.md
Name: scan_frame_loader

Overview:
- Serial scan-in front end that sits directly upstream of the control-signal latch.
- Shifts a serial configuration frame in on SCAN_CLK and checks the bit count.
- Presents the frame as a stable parallel word (PAR_OUT, wired to the latch's CTRL_IN).
- Then generates the LOAD pulse whose rising edge makes the latch capture the word.
- Also provides SCAN_OUT for daisy-chaining further loaders.

Parameters:
- WIDTH, 5, number of control bits per frame (matches the downstream latch width).
- LOAD_CYCLES, 2, number of SCAN_CLK cycles LOAD is held high (>=1).

Ports:
- SCAN_CLK  input  1  the single clock; all state changes on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- SCAN_EN  input  1  frame enable; high while frame bits are presented.
- SCAN_IN  input  1  serial data, sampled when SCAN_EN=1.
- ERR_CLR  input  1  clears the sticky error flags.
- PAR_OUT  output  [0:WIDTH-1]  committed parallel word; drives the downstream CTRL_IN.
- LOAD  output  1  commit strobe; drives the downstream LOAD.
- BUSY  output  1  high while committing; scan input is ignored.
- SCAN_OUT  output  1  shift_reg[0]; serial pass-through for the next loader in the chain.
- FRAME_ERR  output  1  sticky; set when a frame ends with the wrong bit count.
- PARITY_ERR  output  1  sticky; parity failure (0 unless the feature is compiled in).

Behaviour:
- Reset: synchronous, active-high. When RESET=1 at an edge:
  - shift_reg, PAR_OUT, bit count, LOAD, BUSY, FRAME_ERR and PARITY_ERR all go to 0; state goes to IDLE.
  - RESET in the middle of a frame or during LOAD aborts: LOAD drops the next edge, no commit.
- Shifting:
  - Each edge with SCAN_EN=1 in IDLE or SHIFT: shift_reg[i] <= shift_reg[i+1], shift_reg[WIDTH-1] <= SCAN_IN.
  - The first bit of the frame therefore ends in index 0.
  - The count increments and saturates at FLEN+1, where FLEN = WIDTH, or WIDTH+1 with parity.
  - The count width is $clog2(FLEN+2).
- States:
  - IDLE: SCAN_EN=1 -> SHIFT, and the first bit is shifted on that same edge.
  - SHIFT: SCAN_EN=1 -> stay and shift. SCAN_EN=0 -> end of frame, evaluated on this edge:
    - If count==FLEN and the check passes: PAR_OUT <= data bits, go to SETUP.
    - Otherwise: FRAME_ERR or PARITY_ERR <= 1, PAR_OUT unchanged, go to IDLE. No LOAD is issued.
    - The count clears in both cases.
  - SETUP: one cycle so PAR_OUT is stable before LOAD rises. Next edge: LOAD <= 1, go to PULSE.
  - PULSE: LOAD held high for LOAD_CYCLES cycles, then LOAD <= 0 and go to IDLE.
- BUSY is 1 in SETUP and PULSE.
- SCAN_EN/SCAN_IN are ignored in SETUP and PULSE (no shift, no count).
- If SCAN_EN=1 on the first IDLE cycle, a new frame starts then. A frame cut short by BUSY ends in FRAME_ERR.
- Latency: from the edge that samples SCAN_EN=0, PAR_OUT updates at +0 edges and LOAD rises at +1 edge.
- PAR_OUT holds its value between commits.
- Error flags: ERR_CLR=1 clears both flags. If set and clear happen on the same edge, set wins.
- A frame of zero length (SHIFT is never entered) is not an error.

Optional Feature:
- Macro: PARITY_CHECK_EN.
- Defined:
  - A frame is WIDTH data bits followed by 1 odd-parity bit, so FLEN = WIDTH+1.
  - The parity bit is shifted into an extra register stage; PAR_OUT takes the WIDTH data bits.
  - Commit requires the XOR of all FLEN bits to equal 1.
  - Failure sets PARITY_ERR, with no commit and no LOAD.
- Undefined:
  - FLEN = WIDTH; PARITY_ERR is tied to 0.

Decomposition:
- Shared package scan_pkg holds:
  - State encoding constants: IDLE=0, SHIFT=1, SETUP=2, PULSE=3.
  - The default WIDTH/LOAD_CYCLES values.
- One natural sub-module: scan_shift_reg. It holds the shift register plus the saturating bit counter, with shift_en, clr and parallel/count outputs.
- The FSM and error logic stay in the top.

Test Plan (WIDTH=5, LOAD_CYCLES=2, parity off unless stated):
- Reset, then idle for 10 cycles -> PAR_OUT=00000, LOAD=0, BUSY=0, flags 0, SCAN_OUT=0.
- SCAN_EN=1 for 5 cycles with SCAN_IN 1,0,1,1,0, then SCAN_EN=0 -> PAR_OUT[0:4]=1,0,1,1,0 at that edge. LOAD=1 for exactly 2 cycles starting one edge later. BUSY=1 for 3 cycles.
- 4-bit frame and 7-bit frame -> FRAME_ERR=1, no LOAD, PAR_OUT keeps its previous value. ERR_CLR asserted on the same edge as a new error -> FRAME_ERR stays 1.
- RESET asserted in the 3rd shift cycle, and again during PULSE -> all outputs 0 the next edge. A following good frame commits normally.
- SCAN_EN held high through SETUP/PULSE -> bits are ignored. The frame restarts in IDLE and the short remainder sets FRAME_ERR.
- With PARITY_CHECK_EN: data 1,0,1,1,0 + parity 0 (XOR=1) -> commit. Parity 1 -> PARITY_ERR=1, no LOAD.
